sport_tx_serializer: RTL
========================

# sport_tx_serializer

Transmit half of SPORT0. It holds the core-visible 16-bit TX buffer and presents it to the companding stage. It takes back the 8-bit companded word and serializes either the linear or the companded word MSB-first onto DT. Frame sync is generated internally or accepted from an external source, and an interrupt pulse is raised each time the buffer empties into the shifter.

## Interface
- No parameters; word length is run-time programmable.
- SCLK  in  1  serial clock; all state on rising edge. Single clock domain.
- RSTn  in  1  asynchronous, active-low reset.
- sport_en  in  1  port enable; 0 aborts any transfer at the next edge.
- slen  in  4  serial word length minus 1 (valid 3..15; values 0..2 are treated as 3).
- comp_en  in  1  1 = send the companded 8-bit word (length forced to 8).
- itfs  in  1  1 = internal frame sync; 0 = wait for tfs_in.
- afs  in  1  alternate framing (internal sync only).
- tfs_in  in  1  external frame sync, synchronous to SCLK.
- wr_en  in  1  core write strobe for the TX buffer.
- wr_data  in  16  core write data.
- TX  out  16  TX buffer contents, driven to the companding stage.
- logTX  in  8  companded form of TX, combinational from the companding stage.
- DT  out  1  serial data.
- dt_oe  out  1  DT valid/drive enable.
- tfs_out  out  1  frame sync output.
- tx_irq  out  1  one-cycle pulse: buffer transferred to shifter.
- tx_full  out  1  buffer holds an unsent word.
- tx_ovr  out  1  one-cycle pulse: write hit a full buffer.

## Operation
- Reset values: TX = 0, tx_full = 0, and all other outputs 0. FSM enters IDLE, shift register 0, bit counter 0.
- Write: wr_en sets TX = wr_data and tx_full = 1.
  - A write to a full buffer overwrites it and pulses tx_ovr.
  - A write in the same cycle as a transfer is not an overrun: the shifter takes the old word, TX takes the new one, and tx_full stays 1.
- Transfer (load) happens when sport_en = 1, tx_full = 1 and the FSM is in IDLE, or in SHIFT on the last bit.
  - Shifter ← comp_en ? {logTX, 8'h00} : TX << (15 − slen).
  - Counter ← length − 1; tx_full cleared; tx_irq pulses.
- FSM states IDLE, SYNC, SHIFT:
  - IDLE → SYNC on load when itfs = 1 and afs = 0, or when itfs = 0.
  - IDLE → SHIFT directly on load when itfs = 1 and afs = 1.
  - SYNC: with itfs = 1, tfs_out = 1 for one cycle, then SHIFT. With itfs = 0, hold until tfs_in is sampled 1, then SHIFT.
  - SHIFT: DT = shifter MSB and dt_oe = 1. Shift left and decrement each cycle. With afs = 1, tfs_out = 1 during the first bit only.
  - Last bit (counter = 0), word available, itfs = 1: reload. For afs = 0, tfs_out = 1 in this cycle and bits continue gaplessly. For afs = 1, stay in SHIFT; the next cycle carries bit MSB with tfs_out.
  - Last bit, word available, itfs = 0: go to SYNC.
  - Last bit, no word: go to IDLE.
- IDLE: DT = 0, dt_oe = 0, tfs_out = 0.
- sport_en = 0 forces IDLE and clears shifter, counter and tx_full. TX contents are kept.
- RSTn low mid-word: outputs drop to reset values immediately.

## Timing
- Write at edge n. Load at edge n+1, with tx_irq high in cycle n+1.
- Normal internal framing: tfs_out in cycle n+2, first bit in cycle n+3.
- Alternate framing: first bit and tfs_out in cycle n+2.
- An L-bit word occupies L consecutive DT cycles. Back-to-back internal frames have no idle gap.
- External sync: first bit in the cycle after tfs_in is sampled high.
- slen and comp_en are sampled only at load; changing them mid-word has no effect.

## Structure
- Shared package holds the FSM state encoding (IDLE = 2'd0, SYNC = 2'd1, SHIFT = 2'd2), the minimum-length constant (3) and the companded-length constant (8).
- No sub-module; the companding stage stays external and is connected via TX/logTX.

## Test plan
- Write 16'hA5C3, slen = 15, itfs = 1, afs = 0 → tx_irq in the next cycle, tfs_out one cycle later, then DT = 1010010111000011, then dt_oe low.
- slen = 7, write 16'h00B4 → DT = 10110100. Then slen = 1, write 16'h0005 → 4 bits, DT = 0101.
- comp_en = 1, logTX forced to 8'hD5 → DT = 11010101, 8 cycles only.
- Two writes spaced so the second arrives mid-word, afs = 0 → gapless 32 bits, tfs_out during bit 15 of word 1. With afs = 1 → tfs_out on bit 0 of word 2.
- Write while full → tx_ovr pulse and the second value is sent. Write on the same cycle as a load → no tx_ovr, and both words are sent.
- itfs = 0 with tfs_in held low for 5 cycles → DT idle. Then pulse tfs_in → first bit next cycle. Assert RSTn low mid-word → all outputs 0 immediately.

Source files
------------

// File: rtl/sport_tx_serializer_pkg.sv
// Shared definitions for the SPORT0 transmit serializer: FSM encoding,
// word-length limits and the shifter preload helper.
package sport_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } sport_state_e;

    localparam logic [3:0] SLEN_MIN = 4'd3;
    localparam logic [3:0] COMP_LEN = 4'd8;

    typedef struct packed {
        logic [15:0] shreg;
        logic [3:0]  cnt;
    } shift_load_t;

    // Left-justify the word so the MSB of the active length sits at bit 15.
    function automatic shift_load_t shift_load(input logic [15:0] tx_word,
                                               input logic [7:0]  log_word,
                                               input logic [3:0]  slen,
                                               input logic        comp_en);
        shift_load_t r;
        logic [3:0]  len_m1;
        len_m1 = (slen < SLEN_MIN) ? SLEN_MIN : slen;
        if (comp_en) begin
            r.shreg = {log_word, 8'h00};
            r.cnt   = COMP_LEN - 4'd1;
        end else begin
            r.shreg = tx_word << (4'd15 - len_m1);
            r.cnt   = len_m1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sport_tx_serializer_if.sv
// Core-side TX buffer bus of SPORT0: write strobe/data and buffer status.
interface sport_tx_serializer_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        tx_full;
    logic        tx_irq;
    logic        tx_ovr;

    modport master (output wr_en, wr_data, input tx_full, tx_irq, tx_ovr);
    modport slave  (input wr_en, wr_data, output tx_full, tx_irq, tx_ovr);
endinterface

// File: rtl/sport_tx_serializer.sv
// SPORT0 transmit half: TX buffer, frame-sync generation and MSB-first
// serialization of the linear or companded word onto DT.
//
//   state    | meaning
//   ST_IDLE  | no word in flight, DT/dt_oe/tfs_out low
//   ST_SYNC  | word loaded; emit internal sync or wait for tfs_in
//   ST_SHIFT | shifting bits out, reload on the last bit if a word waits
module sport_tx_serializer
    import sport_tx_serializer_pkg::*;
(
    input  logic                        SCLK,
    input  logic                        RSTn,
    input  logic                        sport_en,
    input  logic [3:0]                  slen,
    input  logic                        comp_en,
    input  logic                        itfs,
    input  logic                        afs,
    input  logic                        tfs_in,
    sport_tx_serializer_if.slave        core,
    output logic [15:0]                 TX,
    input  logic [7:0]                  logTX,
    output logic                        DT,
    output logic                        dt_oe,
    output logic                        tfs_out
);

    sport_state_e state;
    logic [15:0]  shreg;
    logic [3:0]   cnt;
    logic         first_bit;
    logic [15:0]  tx_buf;
    logic         full_q;
    logic         irq_q;
    logic         ovr_q;
    logic         dt_q;
    logic         oe_q;
    logic         tfs_q;
    logic         last_bit;
    logic         load;
    shift_load_t  nxt;

    assign last_bit = (state == ST_SHIFT) && (cnt == 4'd0);
    assign load     = sport_en && full_q && ((state == ST_IDLE) || last_bit);
    assign nxt      = shift_load(tx_buf, logTX, slen, comp_en);

    always_ff @(posedge SCLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            shreg     <= 16'h0000;
            cnt       <= 4'd0;
            first_bit <= 1'b0;
            tx_buf    <= 16'h0000;
            full_q    <= 1'b0;
            irq_q     <= 1'b0;
            ovr_q     <= 1'b0;
            dt_q      <= 1'b0;
            oe_q      <= 1'b0;
            tfs_q     <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            ovr_q <= 1'b0;
            dt_q  <= 1'b0;
            oe_q  <= 1'b0;
            tfs_q <= 1'b0;
            if (core.wr_en)
                tx_buf <= core.wr_data;
            if (!sport_en) begin
                state     <= ST_IDLE;
                shreg     <= 16'h0000;
                cnt       <= 4'd0;
                first_bit <= 1'b0;
                full_q    <= 1'b0;
            end else begin
                // A write racing a load refills the buffer without an overrun.
                if (core.wr_en) begin
                    full_q <= 1'b1;
                    ovr_q  <= full_q && !load;
                end else if (load) begin
                    full_q <= 1'b0;
                end
                if (load)
                    irq_q <= 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (load) begin
                            shreg     <= nxt.shreg;
                            cnt       <= nxt.cnt;
                            first_bit <= 1'b1;
                            state     <= (itfs && afs) ? ST_SHIFT : ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (itfs) begin
                            tfs_q <= 1'b1;
                            state <= ST_SHIFT;
                        end else if (tfs_in) begin
                            // External sync: first bit goes out right away.
                            dt_q      <= shreg[15];
                            oe_q      <= 1'b1;
                            shreg     <= shreg << 1;
                            cnt       <= cnt - 4'd1;
                            first_bit <= 1'b0;
                            state     <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        dt_q      <= shreg[15];
                        oe_q      <= 1'b1;
                        tfs_q     <= itfs && afs && first_bit;
                        shreg     <= shreg << 1;
                        cnt       <= cnt - 4'd1;
                        first_bit <= 1'b0;
                        if (last_bit) begin
                            if (load) begin
                                shreg     <= nxt.shreg;
                                cnt       <= nxt.cnt;
                                first_bit <= 1'b1;
                                if (!itfs)
                                    state <= ST_SYNC;
                                else if (!afs)
                                    tfs_q <= 1'b1;
                            end else begin
                                cnt   <= 4'd0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign TX           = tx_buf;
    assign DT           = dt_q;
    assign dt_oe        = oe_q;
    assign tfs_out      = tfs_q;
    assign core.tx_full = full_q;
    assign core.tx_irq  = irq_q;
    assign core.tx_ovr  = ovr_q;

endmodule
